// File: rtl/special_seq_pkg.sv
// Shared definitions for the special-counter code stream
// 000 -> 101 -> 110 -> 010 -> 111 -> 000.
// Provides code constants, the sequence length, the checker state enum
// and next/legal/index helper functions. Used by the counter, the checker
// and test benches.
package special_seq_pkg;

    localparam logic [2:0] SEQ_C0 = 3'b000;
    localparam logic [2:0] SEQ_C1 = 3'b101;
    localparam logic [2:0] SEQ_C2 = 3'b110;
    localparam logic [2:0] SEQ_C3 = 3'b010;
    localparam logic [2:0] SEQ_C4 = 3'b111;

    localparam int SEQ_LEN = 5;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } seq_state_e;

    // Successor in the cycle; illegal codes map to SEQ_C0 (never used
    // for a legal match because the caller also checks legality).
    function automatic logic [2:0] seq_next(input logic [2:0] code);
        case (code)
            SEQ_C0:  return SEQ_C1;
            SEQ_C1:  return SEQ_C2;
            SEQ_C2:  return SEQ_C3;
            SEQ_C3:  return SEQ_C4;
            SEQ_C4:  return SEQ_C0;
            default: return SEQ_C0;
        endcase
    endfunction

    function automatic logic seq_legal(input logic [2:0] code);
        case (code)
            SEQ_C0, SEQ_C1, SEQ_C2, SEQ_C3, SEQ_C4: return 1'b1;
            default:                                return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] seq_index(input logic [2:0] code);
        case (code)
            SEQ_C0:  return 3'd0;
            SEQ_C1:  return 3'd1;
            SEQ_C2:  return 3'd2;
            SEQ_C3:  return 3'd3;
            SEQ_C4:  return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/special_seq_lut.sv
// Combinational lookup of a received code: legality, successor and
// position within the cycle.
// Ports: code (in, 3) ; legal (out, 1) ; nxt (out, 3) ; index (out, 3).
module special_seq_lut
    import special_seq_pkg::*;
(
    input  logic [2:0] code,
    output logic       legal,
    output logic [2:0] nxt,
    output logic [2:0] index
);

    assign legal = seq_legal(code);
    assign nxt   = seq_next(code);
    assign index = seq_index(code);

endmodule

// File: rtl/special_seq_checker.sv
// Receive-side lock/violation checker for the special-counter code stream.
// Ports: clk, rst_n (async active-low), valid, code[2:0], err_clr ;
//        locked, idx[2:0], err, cycle_done, err_cnt[ERR_W-1:0].
// Macro SEQ_CHK_FAST_RESYNC_EN: legal mismatches while locked restart
// acquisition from the offending code instead of going back to HUNT.
module special_seq_checker
    import special_seq_pkg::*;
#(
    parameter int unsigned LOCK_LEN = 2,
    parameter int unsigned ERR_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid,
    input  logic [2:0]       code,
    input  logic             err_clr,
    output logic             locked,
    output logic [2:0]       idx,
    output logic             err,
    output logic             cycle_done,
    output logic [ERR_W-1:0] err_cnt
);

    localparam logic [2:0]       LOCK_N  = 3'(LOCK_LEN);
    localparam logic [ERR_W-1:0] CNT_MAX = '1;
    localparam logic [ERR_W-1:0] CNT_ONE = {{(ERR_W-1){1'b0}}, 1'b1};

    seq_state_e       state_q, state_d;
    logic [2:0]       prev_q, prev_d;
    // Cached successor of prev, so one lookup serves both the incoming
    // code and the expected-next comparison.
    logic [2:0]       exp_q, exp_d;
    logic [2:0]       match_cnt_q, match_cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic             err_q, err_d;
    logic             cycle_done_q, cycle_done_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

    logic       lut_legal;
    logic [2:0] lut_nxt;
    logic [2:0] lut_index;
    logic [2:0] match_inc;
    logic       is_next;
    logic       viol;

    special_seq_lut u_lut (
        .code  (code),
        .legal (lut_legal),
        .nxt   (lut_nxt),
        .index (lut_index)
    );

    assign match_inc = match_cnt_q + 3'd1;
    assign is_next   = lut_legal && (code == exp_q);

    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        exp_d        = exp_q;
        match_cnt_d  = match_cnt_q;
        idx_d        = idx_q;
        err_d        = 1'b0;
        cycle_done_d = 1'b0;
        viol         = 1'b0;

        if (valid) begin
            unique case (state_q)
                HUNT: begin
                    if (lut_legal) begin
                        prev_d      = code;
                        exp_d       = lut_nxt;
                        match_cnt_d = 3'd0;
                        state_d     = ACQ;
                    end
                end
                ACQ: begin
                    if (!lut_legal) begin
                        state_d = HUNT;
                    end else if (is_next) begin
                        prev_d      = code;
                        exp_d       = lut_nxt;
                        match_cnt_d = match_inc;
                        if (match_inc == LOCK_N) begin
                            state_d = LOCKED;
                            idx_d   = lut_index;
                        end
                    end else begin
                        prev_d      = code;
                        exp_d       = lut_nxt;
                        match_cnt_d = 3'd0;
                    end
                end
                LOCKED: begin
                    if (is_next) begin
                        prev_d       = code;
                        exp_d        = lut_nxt;
                        idx_d        = lut_index;
                        cycle_done_d = (prev_q == SEQ_C4);
                    end else begin
                        viol  = 1'b1;
                        err_d = 1'b1;
                        idx_d = 3'd0;
`ifdef SEQ_CHK_FAST_RESYNC_EN
                        if (lut_legal) begin
                            prev_d      = code;
                            exp_d       = lut_nxt;
                            match_cnt_d = 3'd0;
                            state_d     = ACQ;
                        end else begin
                            state_d = HUNT;
                        end
`else
                        state_d = HUNT;
`endif
                    end
                end
                default: begin
                    state_d = HUNT;
                    idx_d   = 3'd0;
                end
            endcase
        end

        // Clear has priority over a same-cycle increment.
        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            err_cnt_d = '0;
        end else if (viol && (err_cnt_q != CNT_MAX)) begin
            err_cnt_d = err_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= HUNT;
            prev_q       <= SEQ_C0;
            exp_q        <= SEQ_C1;
            match_cnt_q  <= 3'd0;
            idx_q        <= 3'd0;
            err_q        <= 1'b0;
            cycle_done_q <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            exp_q        <= exp_d;
            match_cnt_q  <= match_cnt_d;
            idx_q        <= idx_d;
            err_q        <= err_d;
            cycle_done_q <= cycle_done_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign locked     = (state_q == LOCKED);
    assign idx        = idx_q;
    assign err        = err_q;
    assign cycle_done = cycle_done_q;
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_special_seq_checker.sv
// Scoreboard bench for special_seq_checker (LOCK_LEN=2, ERR_W=2).
// Driver pushes hand-computed expectations; monitor pops after each edge.
module tb_special_seq_checker;
    import special_seq_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       valid;
    logic [2:0] code;
    logic       err_clr;
    logic       locked;
    logic [2:0] idx;
    logic       err;
    logic       cycle_done;
    logic [1:0] err_cnt;

    int total = 0;
    int bad   = 0;
    int nbeat = 0;

    // {locked, idx, err, cycle_done, err_cnt}
    logic [7:0] exp_q[$];

    special_seq_checker #(
        .LOCK_LEN (2),
        .ERR_W    (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid      (valid),
        .code       (code),
        .err_clr    (err_clr),
        .locked     (locked),
        .idx        (idx),
        .err        (err),
        .cycle_done (cycle_done),
        .err_cnt    (err_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish (got timeout, want finish)");
        $fatal(1, "watchdog");
    end

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            logic [7:0] want;
            logic [7:0] got;
            want = exp_q.pop_front();
            got  = {locked, idx, err, cycle_done, err_cnt};
            total++;
            nbeat++;
            if (got !== want) begin
                bad++;
                $display("FAIL beat%0d lk/idx/err/cd/cnt got=%b/%0d/%b/%b/%0d want=%b/%0d/%b/%b/%0d",
                         nbeat, got[7], got[6:4], got[3], got[2], got[1:0],
                         want[7], want[6:4], want[3], want[2], want[1:0]);
            end
        end
    end

    task automatic beat(input logic v, input logic [2:0] c, input logic clr,
                        input logic lk, input logic [2:0] ix, input logic e,
                        input logic cd, input logic [1:0] cnt);
        @(negedge clk);
        valid   = v;
        code    = c;
        err_clr = clr;
        exp_q.push_back({lk, ix, e, cd, cnt});
    endtask

    task automatic check_zero(input string name);
        logic [7:0] got;
        got = {locked, idx, err, cycle_done, err_cnt};
        total++;
        if (got !== 8'd0) begin
            bad++;
            $display("FAIL %s outputs got=%b want=00000000", name, got);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        valid   = 1'b0;
        code    = 3'b000;
        err_clr = 1'b0;
        #12;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Clean stream: lock after 3rd beat, wrap pulses cycle_done.
        beat(1, SEQ_C0, 0, 0, 0, 0, 0, 0);
        beat(1, SEQ_C1, 0, 0, 0, 0, 0, 0);
        beat(1, SEQ_C2, 0, 1, 2, 0, 0, 0);
        beat(1, SEQ_C3, 0, 1, 3, 0, 0, 0);
        beat(1, SEQ_C4, 0, 1, 4, 0, 0, 0);
        beat(1, SEQ_C0, 0, 1, 0, 0, 1, 0);
        beat(1, SEQ_C1, 0, 1, 1, 0, 0, 0);
        beat(1, SEQ_C2, 0, 1, 2, 0, 0, 0);
        beat(1, SEQ_C3, 0, 1, 3, 0, 0, 0);
        beat(1, SEQ_C4, 0, 1, 4, 0, 0, 0);
        beat(1, SEQ_C0, 0, 1, 0, 0, 1, 0);
        beat(1, SEQ_C1, 0, 1, 1, 0, 0, 0);

        // Illegal 011 in place of 110: HUNT in both builds, relock in 3.
        beat(1, 3'b011, 0, 0, 0, 1, 0, 1);
        beat(1, SEQ_C3, 0, 0, 0, 0, 0, 1);
        beat(1, SEQ_C4, 0, 0, 0, 0, 0, 1);
        beat(1, SEQ_C0, 0, 1, 0, 0, 0, 1);
        beat(1, SEQ_C1, 0, 1, 1, 0, 0, 1);

        // Legal 111 in place of 110.
        beat(1, SEQ_C4, 0, 0, 0, 1, 0, 2);
`ifdef SEQ_CHK_FAST_RESYNC_EN
        beat(1, SEQ_C0, 0, 0, 0, 0, 0, 2);
        beat(1, SEQ_C1, 0, 1, 1, 0, 0, 2);
        beat(1, SEQ_C2, 0, 1, 2, 0, 0, 2);
`else
        beat(1, SEQ_C0, 0, 0, 0, 0, 0, 2);
        beat(1, SEQ_C1, 0, 0, 0, 0, 0, 2);
        beat(1, SEQ_C2, 0, 1, 2, 0, 0, 2);
`endif

        // valid toggling: idle cycles hold state and give no pulses.
        beat(0, 3'b100, 0, 1, 2, 0, 0, 2);
        beat(1, SEQ_C3, 0, 1, 3, 0, 0, 2);
        beat(0, SEQ_C1, 0, 1, 3, 0, 0, 2);
        beat(1, SEQ_C4, 0, 1, 4, 0, 0, 2);
        beat(0, SEQ_C4, 0, 1, 4, 0, 0, 2);
        beat(1, SEQ_C0, 0, 1, 0, 0, 1, 2);
        beat(0, SEQ_C0, 0, 1, 0, 0, 0, 2);
        beat(1, SEQ_C1, 0, 1, 1, 0, 0, 2);
        beat(0, SEQ_C2, 1, 1, 1, 0, 0, 0);

        // Saturation of the 2-bit counter: 1, 2, 3, 3, then clear wins.
        beat(1, 3'b100, 0, 0, 0, 1, 0, 1);
        beat(1, SEQ_C2, 0, 0, 0, 0, 0, 1);
        beat(1, SEQ_C3, 0, 0, 0, 0, 0, 1);
        beat(1, SEQ_C4, 0, 1, 4, 0, 0, 1);
        beat(1, 3'b001, 0, 0, 0, 1, 0, 2);
        beat(1, SEQ_C0, 0, 0, 0, 0, 0, 2);
        beat(1, SEQ_C1, 0, 0, 0, 0, 0, 2);
        beat(1, SEQ_C2, 0, 1, 2, 0, 0, 2);
        beat(1, 3'b011, 0, 0, 0, 1, 0, 3);
        beat(1, SEQ_C3, 0, 0, 0, 0, 0, 3);
        beat(1, SEQ_C4, 0, 0, 0, 0, 0, 3);
        beat(1, SEQ_C0, 0, 1, 0, 0, 0, 3);
        beat(1, 3'b100, 0, 0, 0, 1, 0, 3);
        beat(1, SEQ_C1, 0, 0, 0, 0, 0, 3);
        beat(1, SEQ_C2, 0, 0, 0, 0, 0, 3);
        beat(1, SEQ_C3, 0, 1, 3, 0, 0, 3);
        beat(1, 3'b100, 1, 0, 0, 1, 0, 0);

        // Relock, then asynchronous reset between edges.
        beat(1, SEQ_C4, 0, 0, 0, 0, 0, 0);
        beat(1, SEQ_C0, 0, 0, 0, 0, 0, 0);
        beat(1, SEQ_C1, 0, 1, 1, 0, 0, 0);
        beat(1, SEQ_C2, 0, 1, 2, 0, 0, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        valid = 1'b0;
        #1;
        check_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        beat(1, SEQ_C3, 0, 0, 0, 0, 0, 0);
        beat(1, SEQ_C4, 0, 0, 0, 0, 0, 0);
        beat(1, SEQ_C0, 0, 1, 0, 0, 0, 0);
        beat(1, SEQ_C1, 0, 1, 1, 0, 0, 0);
        beat(0, SEQ_C1, 0, 1, 1, 0, 0, 0);

        repeat (4) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: pending=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
